traffic_sensor_conditioner: RTL and testbench

//   Conditions the raw lane sensors and drives the start/congestion inputs of traffic_light_fsm.
//   - Synchronises and debounces the raw sensors.
//   - Latches each lane's start sensor as a sticky request, held until the FSM grants that lane green.
//     The FSM looks at a lane's start sensor for only one RED cycle per round, so a latch is needed.
//   - Masks a congestion sensor that is stuck high, so no lane gets an extended green forever.

---
 rtl/traffic_sensor_conditioner.sv | 96 +++++++++
 tb/tb_traffic_sensor_conditioner.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_conditioner.sv
// Sensor front end for traffic_light_fsm: sync, debounce, sticky
// start requests and stuck-congestion masking.
module traffic_sensor_conditioner #(
   parameter int DEB_CYCLES  = 4,
   parameter int DEB_W       = 3,
   parameter int STUCK_LIMIT = 1024,
   parameter int STK_W       = 11
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] raw_s1,
   input  logic [3:0] raw_s5,
   input  logic [3:0] fsm_state,
   output logic [3:0] s1_req,
   output logic [3:0] s5_cong,
   output logic [3:0] s5_fault
);

   localparam logic [15:0] GREEN_CODE = {4'b1011, 4'b1101, 4'b0111, 4'b0001};
   localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
   localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_LIMIT);

   logic [7:0]       sync1_q, sync2_q;
   logic [7:0]       flt_q, flt_d;
   logic [DEB_W-1:0] cnt_q [8];
   logic [DEB_W-1:0] cnt_d [8];
   logic [STK_W-1:0] stk_q [4];
   logic [STK_W-1:0] stk_d [4];
   logic [3:0]       req_q, req_d;
   logic [3:0]       grant;
   logic [3:0]       flt_s1, flt_s5;

   assign flt_s1 = flt_q[3:0];
   assign flt_s5 = flt_q[7:4];

   always_comb begin
      flt_d = flt_q;
      for (int i = 0; i < 8; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != flt_q[i]) begin
            if (cnt_q[i] == DEB_MAX) begin
               flt_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Clear beats set so a granted lane never re-requests during its own green.
   always_comb begin
      grant = '0;
      req_d = '0;
      for (int i = 0; i < 4; i++) begin
         grant[i] = (fsm_state == GREEN_CODE[i*4 +: 4]);
         req_d[i] = (req_q[i] | flt_s1[i]) & ~grant[i];
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         stk_d[i] = '0;
         if (flt_s5[i]) begin
            stk_d[i] = (stk_q[i] == STK_MAX) ? STK_MAX : stk_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         flt_q   <= '0;
         req_q   <= '0;
         for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
         for (int i = 0; i < 4; i++) stk_q[i] <= '0;
      end else begin
         sync1_q <= {raw_s5, raw_s1};
         sync2_q <= sync1_q;
         flt_q   <= flt_d;
         req_q   <= req_d;
         for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
         for (int i = 0; i < 4; i++) stk_q[i] <= stk_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         s5_fault[i] = (stk_q[i] == STK_MAX);
      end
   end

   assign s1_req  = req_q;
   assign s5_cong = flt_s5 & ~s5_fault;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner.
// Runs with DEB_CYCLES=4, STUCK_LIMIT=8.
module tb_traffic_sensor_conditioner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] raw_s1, raw_s5, fsm_state;
   logic [3:0] s1_req, s5_cong, s5_fault;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic       seen;

   traffic_sensor_conditioner #(
      .DEB_CYCLES (4),
      .DEB_W      (3),
      .STUCK_LIMIT(8),
      .STK_W      (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_s1   (raw_s1),
      .raw_s5   (raw_s5),
      .fsm_state(fsm_state),
      .s1_req   (s1_req),
      .s5_cong  (s5_cong),
      .s5_fault (s5_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      raw_s1    = '0;
      raw_s5    = '0;
      fsm_state = '0;
      tick(3);
      chk("rst_req", s1_req, 4'h0);
      chk("rst_cong", s5_cong, 4'h0);
      chk("rst_fault", s5_fault, 4'h0);
      rst_n = 1'b1;
      tick(2);

      // 1: 3-cycle pulse is rejected
      raw_s1 = 4'b0001;
      tick(3);
      raw_s1 = 4'b0000;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (s1_req != 4'h0) seen = 1'b1;
      end
      chk("t1_glitch", seen, 1'b0);

      // 2: sticky request, cleared by EW1 green
      raw_s1 = 4'b0100;
      tick(6);
      chk("t2_e6", s1_req, 4'h0);
      tick();
      chk("t2_e7", s1_req, 4'b0100);
      raw_s1 = 4'b0000;
      tick(8);
      chk("t2_hold", s1_req, 4'b0100);
      fsm_state = 4'b1101;
      tick();
      chk("t2_clr", s1_req, 4'h0);
      fsm_state = 4'b0000;
      tick();
      chk("t2_after", s1_req, 4'h0);

      // 3: held car re-requests after NS2 green ends
      raw_s1 = 4'b0010;
      tick(7);
      chk("t3_req", s1_req, 4'b0010);
      fsm_state = 4'b0111;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_grant", s1_req, 4'h0);
      end
      fsm_state = 4'b0100;
      tick();
      chk("t3_rereq", s1_req, 4'b0010);
      raw_s1 = 4'b0000;
      tick(8);
      fsm_state = 4'b0111;
      tick();
      fsm_state = 4'b0000;
      tick();
      chk("t3_clean", s1_req, 4'h0);

      // 4: stuck congestion on EW2
      raw_s5 = 4'b1000;
      tick(5);
      chk("t4_e5", s5_cong, 4'h0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (s5_cong != 4'b1000 || s5_fault != 4'h0) seen = 1'b1;
      end
      chk("t4_cong8", seen, 1'b0);
      tick();
      chk("t4_fault", s5_fault, 4'b1000);
      chk("t4_mask", s5_cong, 4'h0);
      raw_s5 = 4'b0000;
      tick(6);
      chk("t4_e6rel", s5_fault, 4'b1000);
      tick();
      chk("t4_e7rel", s5_fault, 4'h0);
      chk("t4_cong0", s5_cong, 4'h0);

      // 5: bouncing congestion never passes
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         raw_s5[0] = ((i / 2) % 2) == 0;
         tick();
         if (s5_cong[0]) seen = 1'b1;
      end
      chk("t5_bounce", seen, 1'b0);
      raw_s5 = 4'b0000;
      tick(4);
      raw_s5 = 4'b0001;
      tick(5);
      chk("t5_e5", s5_cong, 4'h0);
      tick();
      chk("t5_e6", s5_cong, 4'b0001);
      raw_s5 = 4'b0000;
      tick(8);
      chk("t5_off", s5_cong, 4'h0);

      // 6: async reset mid-cycle
      raw_s1 = 4'b1011;
      raw_s5 = 4'b0100;
      tick(16);
      chk("t6_req", s1_req, 4'b1011);
      chk("t6_fault", s5_fault, 4'b0100);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_rreq", s1_req, 4'h0);
      chk("t6_rcong", s5_cong, 4'h0);
      chk("t6_rfault", s5_fault, 4'h0);
      #1 rst_n = 1'b1;
      tick(6);
      chk("t6_e6", s1_req, 4'h0);
      tick();
      chk("t6_e7", s1_req, 4'b1011);
      chk("t6_cong", s5_cong, 4'b0100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
